// File: rtl/prco_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// prco_pipe_ctrl
//
// Multi-cycle sequencer for the PRCO core. Steps one instruction at a time
// through FETCH -> DECODE -> DEC_WAIT -> EXEC -> {MEM | UART | WB} -> DONE.
// It drives the fetch, decoder-enable, ALU, RAM, register-writeback and UART
// strobes. It also owns PC advance (increment or jump load) and the
// retired-instruction counter.
//
// Every output is a register. Single-cycle strobes are loaded on the clock
// edge that enters the state they belong to, so each strobe lines up with
// the cycle the FSM spends in that state.
//
// Parameters
//   DEC_TIMEOUT  cycles allowed in DEC_WAIT before the instruction is aborted
//   OP_JMP       opcode that loads the PC instead of incrementing it
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   i_clk         clock, all state on the rising edge
//   i_reset       synchronous, active-low reset
//   i_en          run enable, looked at only at instruction boundaries
//   i_imem_valid  instruction word valid from instruction memory
//   i_dec_ce      decoder: decoded instruction ready
//   i_dec_fetch   decoder: NOP/unknown, skip to the next fetch
//   i_dec_op      decoder opcode
//   i_req_ram     decoder: instruction needs a RAM access
//   i_req_ram_we  decoder: RAM access is a write
//   i_reg_we      decoder: instruction writes the register file
//   i_uart_req    decoder: instruction pushes a byte to the UART
//   i_ram_ack     RAM access complete
//   i_uart_busy   UART transmitter busy
//   q_fetch_req   pulse, start instruction fetch
//   q_dec_ce      pulse, decoder enable
//   q_alu_ce      pulse, ALU evaluate
//   q_ram_req     level, RAM request held until i_ram_ack
//   q_ram_we      level, RAM write qualifier valid with q_ram_req
//   q_reg_we      pulse, register file write
//   q_uart_we     pulse, push byte to UART
//   q_pc_inc      pulse, PC += 1
//   q_pc_load     pulse, PC <= jump target
//   q_err         pulse, decoder timeout
//   q_busy        high in every state except IDLE
//   q_retired     count of completed instructions, wraps to 0
// -----------------------------------------------------------------------------
module prco_pipe_ctrl #(
    parameter int unsigned DEC_TIMEOUT = 4,
    parameter logic [4:0]  OP_JMP      = 5'h0A,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_imem_valid,
    input  logic             i_dec_ce,
    input  logic             i_dec_fetch,
    input  logic [4:0]       i_dec_op,
    input  logic             i_req_ram,
    input  logic             i_req_ram_we,
    input  logic             i_reg_we,
    input  logic             i_uart_req,
    input  logic             i_ram_ack,
    input  logic             i_uart_busy,
    output logic             q_fetch_req,
    output logic             q_dec_ce,
    output logic             q_alu_ce,
    output logic             q_ram_req,
    output logic             q_ram_we,
    output logic             q_reg_we,
    output logic             q_uart_we,
    output logic             q_pc_inc,
    output logic             q_pc_load,
    output logic             q_err,
    output logic             q_busy,
    output logic [CNT_W-1:0] q_retired
);

    // The timeout counter runs 0 .. DEC_TIMEOUT-1 while the decoder is silent.
    localparam int unsigned      TMO_W    = (DEC_TIMEOUT > 1) ? $clog2(DEC_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DEC_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_DEC_WAIT = 4'd3,
        S_EXEC     = 4'd4,
        S_MEM      = 4'd5,
        S_UART     = 4'd6,
        S_WB       = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t           state_r;
    logic [TMO_W-1:0] tmo_cnt_r;

    // Decoder outputs captured on i_dec_ce; they steer EXEC/MEM/DONE.
    logic [4:0]       op_r;
    logic             req_ram_r;
    logic             ram_we_r;
    logic             reg_we_r;
    logic             uart_req_r;

    function automatic logic is_jmp_f(input logic [4:0] op);
        return (op == OP_JMP);
    endfunction

    // Sequencer: state, timeout counter, latched decoder flags, all outputs
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_r     <= S_IDLE;
            tmo_cnt_r   <= {TMO_W{1'b0}};
            op_r        <= 5'd0;
            req_ram_r   <= 1'b0;
            ram_we_r    <= 1'b0;
            reg_we_r    <= 1'b0;
            uart_req_r  <= 1'b0;
            q_fetch_req <= 1'b0;
            q_dec_ce    <= 1'b0;
            q_alu_ce    <= 1'b0;
            q_ram_req   <= 1'b0;
            q_ram_we    <= 1'b0;
            q_reg_we    <= 1'b0;
            q_uart_we   <= 1'b0;
            q_pc_inc    <= 1'b0;
            q_pc_load   <= 1'b0;
            q_err       <= 1'b0;
            q_busy      <= 1'b0;
            q_retired   <= {CNT_W{1'b0}};
        end else begin
            // Strobes fall back to zero unless the transition below re-arms them.
            q_fetch_req <= 1'b0;
            q_dec_ce    <= 1'b0;
            q_alu_ce    <= 1'b0;
            q_reg_we    <= 1'b0;
            q_uart_we   <= 1'b0;
            q_pc_inc    <= 1'b0;
            q_pc_load   <= 1'b0;
            q_err       <= 1'b0;

            case (state_r)
                S_IDLE: begin
                    if (i_en) begin
                        state_r     <= S_FETCH;
                        q_fetch_req <= 1'b1;
                        q_busy      <= 1'b1;
                    end else begin
                        state_r     <= S_IDLE;
                    end
                end

                S_FETCH: begin
                    if (i_imem_valid) begin
                        state_r  <= S_DECODE;
                        q_dec_ce <= 1'b1;
                    end else begin
                        state_r  <= S_FETCH;
                    end
                end

                S_DECODE: begin
                    state_r   <= S_DEC_WAIT;
                    tmo_cnt_r <= {TMO_W{1'b0}};
                end

                S_DEC_WAIT: begin
                    if (i_dec_ce) begin
                        // A decoded instruction wins over a simultaneous skip.
                        state_r    <= S_EXEC;
                        q_alu_ce   <= 1'b1;
                        op_r       <= i_dec_op;
                        req_ram_r  <= i_req_ram;
                        ram_we_r   <= i_req_ram_we;
                        reg_we_r   <= i_reg_we;
                        uart_req_r <= i_uart_req;
                    end else if (i_dec_fetch) begin
                        // NOP: retire and step the PC; flags are cleared so a
                        // stale jump opcode cannot turn this into a PC load.
                        state_r    <= S_DONE;
                        op_r       <= 5'd0;
                        req_ram_r  <= 1'b0;
                        ram_we_r   <= 1'b0;
                        reg_we_r   <= 1'b0;
                        uart_req_r <= 1'b0;
                        q_pc_inc   <= 1'b1;
                        q_retired  <= q_retired + CNT_W'(1);
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        // Decoder never answered: abort and refetch, PC untouched.
                        state_r     <= S_FETCH;
                        q_err       <= 1'b1;
                        q_fetch_req <= 1'b1;
                    end else begin
                        state_r   <= S_DEC_WAIT;
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end

                S_EXEC: begin
                    if (req_ram_r) begin
                        state_r   <= S_MEM;
                        q_ram_req <= 1'b1;
                        q_ram_we  <= ram_we_r;
                    end else if (uart_req_r) begin
                        state_r   <= S_UART;
                    end else if (reg_we_r) begin
                        state_r   <= S_WB;
                        q_reg_we  <= 1'b1;
                    end else begin
                        state_r   <= S_DONE;
                        q_pc_load <= is_jmp_f(op_r);
                        q_pc_inc  <= !is_jmp_f(op_r);
                        q_retired <= q_retired + CNT_W'(1);
                    end
                end

                S_MEM: begin
                    if (i_ram_ack) begin
                        q_ram_req <= 1'b0;
                        q_ram_we  <= 1'b0;
                        if (reg_we_r) begin
                            state_r   <= S_WB;
                            q_reg_we  <= 1'b1;
                        end else begin
                            state_r   <= S_DONE;
                            q_pc_load <= is_jmp_f(op_r);
                            q_pc_inc  <= !is_jmp_f(op_r);
                            q_retired <= q_retired + CNT_W'(1);
                        end
                    end else begin
                        state_r <= S_MEM;
                    end
                end

                S_UART: begin
                    // q_uart_we is raised for the last UART cycle, then DONE.
                    if (q_uart_we) begin
                        state_r   <= S_DONE;
                        q_pc_load <= is_jmp_f(op_r);
                        q_pc_inc  <= !is_jmp_f(op_r);
                        q_retired <= q_retired + CNT_W'(1);
                    end else if (!i_uart_busy) begin
                        state_r   <= S_UART;
                        q_uart_we <= 1'b1;
                    end else begin
                        state_r   <= S_UART;
                    end
                end

                S_WB: begin
                    state_r   <= S_DONE;
                    q_pc_load <= is_jmp_f(op_r);
                    q_pc_inc  <= !is_jmp_f(op_r);
                    q_retired <= q_retired + CNT_W'(1);
                end

                S_DONE: begin
                    if (i_en) begin
                        state_r     <= S_FETCH;
                        q_fetch_req <= 1'b1;
                        q_busy      <= 1'b1;
                    end else begin
                        state_r     <= S_IDLE;
                        q_busy      <= 1'b0;
                    end
                end

                default: begin
                    state_r   <= S_IDLE;
                    q_ram_req <= 1'b0;
                    q_ram_we  <= 1'b0;
                    q_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prco_pipe_ctrl.sv
// Directed bench for prco_pipe_ctrl. All outputs are packed into one vector
// and compared against hand-built expectations every cycle of each sequence.
// A 4-bit retired counter is used so the wrap point is reachable quickly.
module tb_prco_pipe_ctrl;

    localparam int unsigned TB_CNT_W = 4;
    localparam logic [4:0]  OP_JMP   = 5'h0A;
    localparam logic [4:0]  OP_ADD   = 5'h01;
    localparam logic [4:0]  OP_LW    = 5'h08;
    localparam logic [4:0]  OP_SW    = 5'h09;
    localparam logic [4:0]  OP_WR    = 5'h0C;

    // Output vector bit positions
    localparam logic [10:0] O_FETCH = 11'h400;
    localparam logic [10:0] O_DEC   = 11'h200;
    localparam logic [10:0] O_ALU   = 11'h100;
    localparam logic [10:0] O_RAMRQ = 11'h080;
    localparam logic [10:0] O_RAMWE = 11'h040;
    localparam logic [10:0] O_REGWE = 11'h020;
    localparam logic [10:0] O_UART  = 11'h010;
    localparam logic [10:0] O_PCINC = 11'h008;
    localparam logic [10:0] O_PCLD  = 11'h004;
    localparam logic [10:0] O_ERR   = 11'h002;
    localparam logic [10:0] O_BUSY  = 11'h001;
    localparam logic [10:0] O_NONE  = 11'h000;

    logic i_clk = 1'b0;
    logic i_reset, i_en, i_imem_valid, i_dec_ce, i_dec_fetch;
    logic [4:0] i_dec_op;
    logic i_req_ram, i_req_ram_we, i_reg_we, i_uart_req, i_ram_ack, i_uart_busy;
    logic q_fetch_req, q_dec_ce, q_alu_ce, q_ram_req, q_ram_we, q_reg_we;
    logic q_uart_we, q_pc_inc, q_pc_load, q_err, q_busy;
    logic [TB_CNT_W-1:0] q_retired;
    logic [10:0] outs;

    int n_checks = 0;
    int n_errors = 0;
    logic [TB_CNT_W-1:0] exp_ret = '0;

    always #5 i_clk = ~i_clk;

    assign outs = {q_fetch_req, q_dec_ce, q_alu_ce, q_ram_req, q_ram_we, q_reg_we,
                   q_uart_we, q_pc_inc, q_pc_load, q_err, q_busy};

    prco_pipe_ctrl #(.DEC_TIMEOUT(4), .OP_JMP(OP_JMP), .CNT_W(TB_CNT_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_imem_valid(i_imem_valid),
        .i_dec_ce(i_dec_ce), .i_dec_fetch(i_dec_fetch), .i_dec_op(i_dec_op),
        .i_req_ram(i_req_ram), .i_req_ram_we(i_req_ram_we), .i_reg_we(i_reg_we),
        .i_uart_req(i_uart_req), .i_ram_ack(i_ram_ack), .i_uart_busy(i_uart_busy),
        .q_fetch_req(q_fetch_req), .q_dec_ce(q_dec_ce), .q_alu_ce(q_alu_ce),
        .q_ram_req(q_ram_req), .q_ram_we(q_ram_we), .q_reg_we(q_reg_we),
        .q_uart_we(q_uart_we), .q_pc_inc(q_pc_inc), .q_pc_load(q_pc_load),
        .q_err(q_err), .q_busy(q_busy), .q_retired(q_retired)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_outs(input string tag, input logic [10:0] exp);
        chk(tag, {21'd0, outs}, {21'd0, exp});
    endtask

    // From a FETCH cycle: instruction arrives at once, DECODE, then DEC_WAIT.
    task automatic fetch_decode(input string tag);
        i_imem_valid = 1'b1;
        tick();
        exp_outs({tag, "_decode"}, O_DEC | O_BUSY);
        i_imem_valid = 1'b0;
        tick();
        exp_outs({tag, "_decwait"}, O_BUSY);
    endtask

    // Decoder answers during DEC_WAIT; the next cycle is EXEC.
    task automatic dec_resp(input string tag, input logic [4:0] op, input logic ram,
                            input logic ram_we, input logic reg_we, input logic uart);
        i_dec_ce = 1'b1; i_dec_op = op; i_req_ram = ram; i_req_ram_we = ram_we;
        i_reg_we = reg_we; i_uart_req = uart;
        tick();
        exp_outs({tag, "_exec"}, O_ALU | O_BUSY);
        i_dec_ce = 1'b0; i_dec_op = 5'd0; i_req_ram = 1'b0; i_req_ram_we = 1'b0;
        i_reg_we = 1'b0; i_uart_req = 1'b0;
    endtask

    // Called in the DONE cycle: checks the PC strobe and the retired count.
    task automatic done_chk(input string tag, input logic jmp);
        exp_outs({tag, "_done"}, (jmp ? O_PCLD : O_PCINC) | O_BUSY);
        exp_ret = exp_ret + 1'b1;
        chk({tag, "_retired"}, {28'd0, q_retired}, {28'd0, exp_ret});
    endtask

    task automatic nop_instr(input string tag);
        fetch_decode(tag);
        i_dec_fetch = 1'b1;
        tick();
        i_dec_fetch = 1'b0;
        done_chk(tag, 1'b0);
        tick();
        exp_outs({tag, "_refetch"}, O_FETCH | O_BUSY);
    endtask

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset = 1'b0; i_en = 1'b0; i_imem_valid = 1'b0; i_dec_ce = 1'b0;
        i_dec_fetch = 1'b0; i_dec_op = 5'd0; i_req_ram = 1'b0; i_req_ram_we = 1'b0;
        i_reg_we = 1'b0; i_uart_req = 1'b0; i_ram_ack = 1'b0; i_uart_busy = 1'b0;

        // Reset state
        repeat (3) tick();
        exp_outs("reset_outs", O_NONE);
        chk("reset_retired", {28'd0, q_retired}, 32'd0);

        // Release with run enable: first edge takes IDLE -> FETCH
        i_reset = 1'b1; i_en = 1'b1;
        tick();
        exp_outs("start_fetch", O_FETCH | O_BUSY);

        // ADD: ALU then WB then PC increment
        fetch_decode("add");
        dec_resp("add", OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); exp_outs("add_wb", O_REGWE | O_BUSY);
        tick(); done_chk("add", 1'b0);
        tick(); exp_outs("add_refetch", O_FETCH | O_BUSY);

        // LW with ack late: ram_req held four cycles, read, then WB
        fetch_decode("lw");
        dec_resp("lw", OP_LW, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); exp_outs("lw_mem", O_RAMRQ | O_BUSY);
        end
        i_ram_ack = 1'b1;
        tick(); exp_outs("lw_wb", O_REGWE | O_BUSY);
        i_ram_ack = 1'b0;
        tick(); done_chk("lw", 1'b0);
        tick(); exp_outs("lw_refetch", O_FETCH | O_BUSY);

        // SW: write qualifier set, no register writeback
        fetch_decode("sw");
        dec_resp("sw", OP_SW, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); exp_outs("sw_mem", O_RAMRQ | O_RAMWE | O_BUSY);
        i_ram_ack = 1'b1;
        tick(); done_chk("sw", 1'b0);
        i_ram_ack = 1'b0;
        tick(); exp_outs("sw_refetch", O_FETCH | O_BUSY);

        // UART write held off by busy, one strobe on the first idle cycle
        fetch_decode("wr");
        i_uart_busy = 1'b1;
        dec_resp("wr", OP_WR, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(); exp_outs("wr_busy", O_BUSY);
        end
        i_uart_busy = 1'b0;
        tick(); exp_outs("wr_push", O_UART | O_BUSY);
        tick(); done_chk("wr", 1'b0);
        tick(); exp_outs("wr_refetch", O_FETCH | O_BUSY);

        // JMP with reg_we: WB then PC load, no increment
        fetch_decode("jmp");
        dec_resp("jmp", OP_JMP, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); exp_outs("jmp_wb", O_REGWE | O_BUSY);
        tick(); done_chk("jmp", 1'b1);
        tick(); exp_outs("jmp_refetch", O_FETCH | O_BUSY);

        // NOP right after a JMP: no ALU strobe, increments the PC
        nop_instr("nop");

        // dec_ce and dec_fetch together: the decoded instruction executes
        fetch_decode("both");
        i_dec_fetch = 1'b1;
        dec_resp("both", OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        i_dec_fetch = 1'b0;
        tick(); done_chk("both", 1'b0);
        tick(); exp_outs("both_refetch", O_FETCH | O_BUSY);

        // Silent decoder: four DEC_WAIT cycles, then error + refetch, no PC strobe
        fetch_decode("tmo");
        for (int i = 0; i < 3; i++) begin
            tick(); exp_outs("tmo_wait", O_BUSY);
        end
        tick(); exp_outs("tmo_err", O_FETCH | O_ERR | O_BUSY);
        chk("tmo_retired", {28'd0, q_retired}, {28'd0, exp_ret});

        // Enable dropped mid-instruction: finishes, then IDLE
        fetch_decode("stop");
        i_en = 1'b0;
        dec_resp("stop", OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); done_chk("stop", 1'b0);
        tick(); exp_outs("stop_idle", O_NONE);
        tick(); exp_outs("stop_idle_hold", O_NONE);

        // Run NOPs to the top of the counter, then one more wraps it to 0
        i_en = 1'b1;
        tick(); exp_outs("wrap_fetch", O_FETCH | O_BUSY);
        while (exp_ret != 4'hF) nop_instr("fill");
        nop_instr("wrap");
        chk("wrap_zero", {28'd0, q_retired}, 32'd0);

        // Reset taken from MEM with ram_req high
        fetch_decode("rmem");
        dec_resp("rmem", OP_SW, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); exp_outs("rmem_mem", O_RAMRQ | O_RAMWE | O_BUSY);
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); exp_outs("rmem_reset", O_NONE);
        end
        chk("rmem_retired", {28'd0, q_retired}, 32'd0);
        exp_ret = '0;
        i_reset = 1'b1;
        tick(); exp_outs("rmem_restart", O_FETCH | O_BUSY);
        nop_instr("post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
